// File: rtl/kernel_sequencer_pkg.sv
// kernel_sequencer shared definitions: register map, CTRL/STATUS bit
// positions, feed FSM states and the LENGTH saturation helper.
package kernel_sequencer_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 9;

    localparam logic [LEN_W-1:0] MAX_LENGTH = 9'd256;

    localparam logic [ADDR_W-1:0] REG_CTRL     = 8'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 8'h01;
    localparam logic [ADDR_W-1:0] REG_LENGTH   = 8'h02;
    localparam logic [ADDR_W-1:0] REG_BASE_IN  = 8'h03;
    localparam logic [ADDR_W-1:0] REG_BASE_OUT = 8'h04;
    localparam logic [ADDR_W-1:0] REG_RES_CNT  = 8'h05;
    localparam logic [ADDR_W-1:0] REG_CYCLES   = 8'h06;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_PRESENT,
        S_DRAIN
    } feed_state_t;

    function automatic logic [LEN_W-1:0] sat_length(input logic [DATA_W-1:0] v);
        return (v > 32'(MAX_LENGTH)) ? MAX_LENGTH : v[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/kernel_sequencer_csr.sv
// kernel_sequencer register block: write decode, sticky DONE/ABORTED,
// configuration registers, registered readback (latency 1) and irq.
// Ports: ctrl_* register bus; busy/start_go/set_done/set_aborted and
// result_count/cycles from the sequencer; start_req/abort_req pulses and
// length/base_in/base_out configuration back to it; irq out.
module kernel_sequencer_csr
    import kernel_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ctrl_address,
    input  logic              ctrl_read,
    input  logic              ctrl_write,
    input  logic [DATA_W-1:0] ctrl_writedata,
    output logic [DATA_W-1:0] ctrl_readdata,
    input  logic              busy,
    input  logic              start_go,
    input  logic              set_done,
    input  logic              set_aborted,
    input  logic [LEN_W-1:0]  result_count,
    input  logic [DATA_W-1:0] cycles,
    output logic              start_req,
    output logic              abort_req,
    output logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] base_out,
    output logic              irq
);

    logic wr_ctrl;
    logic wr_status;
    logic wr_length;
    logic wr_base_in;
    logic wr_base_out;
    logic irq_en;
    logic done;
    logic aborted;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        wr_ctrl     = 1'b0;
        wr_status   = 1'b0;
        wr_length   = 1'b0;
        wr_base_in  = 1'b0;
        wr_base_out = 1'b0;
        if (ctrl_write) begin
            unique case (1'b1)
                (ctrl_address == REG_CTRL):     wr_ctrl     = 1'b1;
                (ctrl_address == REG_STATUS):   wr_status   = 1'b1;
                (ctrl_address == REG_LENGTH):   wr_length   = 1'b1;
                (ctrl_address == REG_BASE_IN):  wr_base_in  = 1'b1;
                (ctrl_address == REG_BASE_OUT): wr_base_out = 1'b1;
                default: ;
            endcase
        end
    end

    // ABORT dominates: a combined START|ABORT write never launches a job.
    assign start_req = wr_ctrl & ctrl_writedata[CTRL_START]
                     & ~ctrl_writedata[CTRL_ABORT];
    assign abort_req = wr_ctrl & ctrl_writedata[CTRL_ABORT];

    assign irq = done & irq_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            length   <= '0;
            base_in  <= '0;
            base_out <= '0;
        end else begin
            if (wr_ctrl)
                irq_en <= ctrl_writedata[CTRL_IRQ_EN];
            // A zero-length START both clears and sets DONE; setting wins.
            if (set_done)
                done <= 1'b1;
            else if (start_go)
                done <= 1'b0;
            else if (wr_status && ctrl_writedata[STAT_DONE])
                done <= 1'b0;
            if (set_aborted)
                aborted <= 1'b1;
            else if (start_go)
                aborted <= 1'b0;
            if (!busy) begin
                if (wr_length)
                    length <= sat_length(ctrl_writedata);
                if (wr_base_in)
                    base_in <= ctrl_writedata[ADDR_W-1:0];
                if (wr_base_out)
                    base_out <= ctrl_writedata[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (ctrl_address == REG_CTRL):
                rd_mux[CTRL_IRQ_EN] = irq_en;
            (ctrl_address == REG_STATUS): begin
                rd_mux[STAT_BUSY]    = busy;
                rd_mux[STAT_DONE]    = done;
                rd_mux[STAT_ABORTED] = aborted;
            end
            (ctrl_address == REG_LENGTH):
                rd_mux[LEN_W-1:0] = length;
            (ctrl_address == REG_BASE_IN):
                rd_mux[ADDR_W-1:0] = base_in;
            (ctrl_address == REG_BASE_OUT):
                rd_mux[ADDR_W-1:0] = base_out;
            (ctrl_address == REG_RES_CNT):
                rd_mux[LEN_W-1:0] = result_count;
            (ctrl_address == REG_CYCLES):
                rd_mux = cycles;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ctrl_readdata <= '0;
        else if (ctrl_read)
            ctrl_readdata <= rd_mux;
    end

endmodule

// File: rtl/kernel_sequencer.sv
// kernel_sequencer: streams LENGTH words from the input buffer into a
// kernel and writes its results to the output buffer, then flags DONE.
// Ports: clk_clk/reset_reset_n (sync, active-low); ctrl_* HPS register
// port; in_ram_* input buffer read; out_ram_* output buffer write;
// k_in_* / k_out_* kernel streams; k_flush abort pulse; irq.
// Option: KERNEL_SEQUENCER_CYCLE_COUNT_EN enables the BUSY cycle counter.
module kernel_sequencer
    import kernel_sequencer_pkg::*;
(
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] ctrl_address,
    input  logic              ctrl_read,
    input  logic              ctrl_write,
    input  logic [DATA_W-1:0] ctrl_writedata,
    output logic [DATA_W-1:0] ctrl_readdata,
    output logic [ADDR_W-1:0] in_ram_address,
    input  logic [DATA_W-1:0] in_ram_readdata,
    output logic [ADDR_W-1:0] out_ram_address,
    output logic              out_ram_write,
    output logic [DATA_W-1:0] out_ram_writedata,
    output logic              k_in_valid,
    input  logic              k_in_ready,
    output logic [DATA_W-1:0] k_in_data,
    input  logic              k_out_valid,
    output logic              k_out_ready,
    input  logic [DATA_W-1:0] k_out_data,
    output logic              k_flush,
    output logic              irq
);

    feed_state_t state;
    feed_state_t state_nxt;

    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  rd_cnt_inc;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  wr_cnt_nxt;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] base_out;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] cycles;

    logic busy;
    logic start_req;
    logic abort_req;
    logic start_go;
    logic abort_go;
    logic set_done;
    logic in_fire;
    logic out_fire;
    logic all_written;

    kernel_sequencer_csr u_csr (
        .clk            (clk_clk),
        .rst_n          (reset_reset_n),
        .ctrl_address   (ctrl_address),
        .ctrl_read      (ctrl_read),
        .ctrl_write     (ctrl_write),
        .ctrl_writedata (ctrl_writedata),
        .ctrl_readdata  (ctrl_readdata),
        .busy           (busy),
        .start_go       (start_go),
        .set_done       (set_done),
        .set_aborted    (abort_go),
        .result_count   (wr_cnt),
        .cycles         (cycles),
        .start_req      (start_req),
        .abort_req      (abort_req),
        .length         (length),
        .base_in        (base_in),
        .base_out       (base_out),
        .irq            (irq)
    );

    assign busy        = (state != S_IDLE);
    assign k_in_valid  = (state == S_PRESENT);
    assign k_in_data   = operand;
    assign in_fire     = k_in_valid & k_in_ready;
    assign k_out_ready = busy & (wr_cnt < length);
    assign out_fire    = k_out_valid & k_out_ready;
    assign rd_cnt_inc  = rd_cnt + 9'd1;
    assign wr_cnt_nxt  = wr_cnt + {8'd0, out_fire};

    // Look at the post-write count so DONE lands the cycle after the
    // last result write rather than one cycle later.
    assign all_written = (wr_cnt_nxt == length);

    // Addresses wrap naturally in 8 bits; idle values are held at zero.
    assign in_ram_address    = (state == S_ISSUE) ? base_in + rd_cnt[7:0] : '0;
    assign out_ram_write     = out_fire;
    assign out_ram_address   = out_fire ? base_out + wr_cnt[7:0] : '0;
    assign out_ram_writedata = out_fire ? k_out_data : '0;

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        abort_go  = 1'b0;
        set_done  = 1'b0;
        if (busy && abort_req) begin
            abort_go  = 1'b1;
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_req) begin
                        start_go = 1'b1;
                        if (length == '0)
                            set_done = 1'b1;
                        else
                            state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE:   state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_PRESENT;
                S_PRESENT: begin
                    if (in_fire) begin
                        if (rd_cnt_inc < length) begin
                            state_nxt = S_ISSUE;
                        end else if (all_written) begin
                            state_nxt = S_IDLE;
                            set_done  = 1'b1;
                        end else begin
                            state_nxt = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (all_written) begin
                        state_nxt = S_IDLE;
                        set_done  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state   <= S_IDLE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            operand <= '0;
            k_flush <= 1'b0;
        end else begin
            state   <= state_nxt;
            k_flush <= abort_go;
            if (start_go) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (in_fire)
                    rd_cnt <= rd_cnt_inc;
                wr_cnt <= wr_cnt_nxt;
            end
            if (state == S_CAPTURE)
                operand <= in_ram_readdata;
        end
    end

`ifdef KERNEL_SEQUENCER_CYCLE_COUNT_EN
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            cycles <= '0;
        else if (start_go)
            cycles <= '0;
        else if (busy && (cycles != '1))
            cycles <= cycles + 32'd1;
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed bench for kernel_sequencer with buffer RAM and echo-kernel
// models; result writes are checked against a queue of expected writes.
module tb_kernel_sequencer;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h01;
    localparam logic [7:0] A_LEN    = 8'h02;
    localparam logic [7:0] A_BIN    = 8'h03;
    localparam logic [7:0] A_BOUT   = 8'h04;
    localparam logic [7:0] A_RCNT   = 8'h05;
    localparam logic [7:0] A_CYC    = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ctrl_address;
    logic        ctrl_read;
    logic        ctrl_write;
    logic [31:0] ctrl_writedata;
    logic [31:0] ctrl_readdata;
    logic [7:0]  in_ram_address;
    logic [31:0] in_ram_readdata;
    logic [7:0]  out_ram_address;
    logic        out_ram_write;
    logic [31:0] out_ram_writedata;
    logic        k_in_valid;
    logic        k_in_ready;
    logic [31:0] k_in_data;
    logic        k_out_valid;
    logic        k_out_ready;
    logic [31:0] k_out_data;
    logic        k_flush;
    logic        irq;

    kernel_sequencer dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .ctrl_address      (ctrl_address),
        .ctrl_read         (ctrl_read),
        .ctrl_write        (ctrl_write),
        .ctrl_writedata    (ctrl_writedata),
        .ctrl_readdata     (ctrl_readdata),
        .in_ram_address    (in_ram_address),
        .in_ram_readdata   (in_ram_readdata),
        .out_ram_address   (out_ram_address),
        .out_ram_write     (out_ram_write),
        .out_ram_writedata (out_ram_writedata),
        .k_in_valid        (k_in_valid),
        .k_in_ready        (k_in_ready),
        .k_in_data         (k_in_data),
        .k_out_valid       (k_out_valid),
        .k_out_ready       (k_out_ready),
        .k_out_data        (k_out_data),
        .k_flush           (k_flush),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] in_mem [256];
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];
    int n_pass = 0;
    int n_total = 0;
    int hs_cnt = 0;
    int act_cnt = 0;
    int busy_cyc = 0;

    always @(posedge clk) in_ram_readdata <= in_mem[in_ram_address];

    // Echo kernel: one result register, accepts only when it is empty.
    logic        ready_en;
    logic        res_valid;
    logic [31:0] res;
    assign k_in_ready  = ready_en & ~res_valid;
    assign k_out_valid = res_valid;
    assign k_out_data  = res;

    always @(posedge clk) begin
        if (!rst_n || k_flush) begin
            res_valid <= 1'b0;
        end else begin
            if (k_out_valid && k_out_ready) res_valid <= 1'b0;
            if (k_in_valid && k_in_ready) begin
                res_valid <= 1'b1;
                res       <= k_in_data;
            end
        end
    end

    always @(posedge clk) begin
        if (out_ram_write) obs_q.push_back({24'd0, out_ram_address, out_ram_writedata});
        if (k_in_valid && k_in_ready) hs_cnt <= hs_cnt + 1;
        if (in_ram_address != 0 || k_in_valid || out_ram_write) act_cnt <= act_cnt + 1;
        if (k_out_ready) busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        ctrl_address = a; ctrl_writedata = d; ctrl_write = 1'b1;
        @(negedge clk);
        ctrl_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        ctrl_address = a; ctrl_read = 1'b1;
        @(negedge clk);
        ctrl_read = 1'b0;
        d = ctrl_readdata;
    endtask

    task automatic load_job(input logic [7:0] bi, input logic [7:0] bo,
                            input int n, input logic [31:0] v0);
        for (int i = 0; i < n; i++) begin
            in_mem[8'(bi + i)] = v0 + 32'(i);
            exp_q.push_back({24'd0, 8'(bo + i), v0 + 32'(i)});
        end
    endtask

    // Polls STATUS every cycle; readdata at negedge n shows cycle n-1,
    // so DONE in cycle W+1 appears two samples after the last write W.
    task automatic run_job(input string tag, input int n_exp, input logic exp_irq);
        int wc = 0;
        int wcyc = -1;
        int dcyc = -1;
        logic irq_s = 1'b0;
        ctrl_address = A_STATUS; ctrl_read = 1'b1;
        for (int n = 0; n < 3000 && dcyc < 0; n++) begin
            @(negedge clk);
            if (out_ram_write) begin
                wc++;
                if (wc == n_exp) wcyc = n;
            end
            if (wcyc >= 0 && n == wcyc + 1) irq_s = irq;
            if (n > 0 && ctrl_readdata[1]) dcyc = n;
        end
        ctrl_read = 1'b0;
        chk({tag, "_done_seen"}, 64'(dcyc >= 0), 64'd1);
        chk({tag, "_done_lat"}, 64'(dcyc - wcyc), 64'd2);
        chk({tag, "_irq"}, 64'(irq_s), 64'(exp_irq));
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            logic [63:0] o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD;
            chk({tag, "_wr"}, o, e);
        end
        chk({tag, "_extra_wr"}, 64'(obs_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d0;
        int base;
        int stable_err;
        int seen;
        rst_n = 1'b0; ctrl_address = '0; ctrl_read = 1'b0;
        ctrl_write = 1'b0; ctrl_writedata = '0; ready_en = 1'b1;
        for (int i = 0; i < 256; i++) in_mem[i] = 32'hBAD0_0000 + 32'(i);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_a", {ctrl_readdata, in_ram_address, out_ram_address,
                      out_ram_write, k_in_valid, k_flush, irq}, 64'd0);
        chk("rst_b", {out_ram_writedata, k_in_data}, 64'd0);
        chk("rst_c", {63'd0, k_out_ready}, 64'd0);
        rd(A_STATUS, d); chk("rst_status", 64'(d), 64'd0);
        rd(A_LEN, d);    chk("rst_len", 64'(d), 64'd0);

        // Basic echo job
        load_job(8'h10, 8'h20, 4, 32'd1);
        wr(A_LEN, 4); wr(A_BIN, 8'h10); wr(A_BOUT, 8'h20);
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, d); chk("j1_busy_t1", 64'(d), 64'h1);
        chk("j1_kvalid_t2", 64'(k_in_valid), 64'd0);
        @(negedge clk);
        chk("j1_kvalid_t3", 64'(k_in_valid), 64'd1);
        chk("j1_kdata_t3", 64'(k_in_data), 64'd1);
        run_job("j1", 4, 1'b0);
        rd(A_STATUS, d); chk("j1_status", 64'(d), 64'h2);
        rd(A_RCNT, d);   chk("j1_rcnt", 64'(d), 64'd4);

        // Address wrap on both buffers
        load_job(8'hFE, 8'hFF, 3, 32'hC0DE_0100);
        wr(A_LEN, 3); wr(A_BIN, 8'hFE); wr(A_BOUT, 8'hFF);
        wr(A_CTRL, 32'h1);
        run_job("wrap", 3, 1'b0);

        // LENGTH saturation and zero-length job
        wr(A_LEN, 1000);
        rd(A_LEN, d); chk("len_sat", 64'(d), 64'd256);
        wr(A_LEN, 0);
        base = act_cnt;
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, d); chk("len0_status", 64'(d), 64'h2);
        repeat (5) @(negedge clk);
        chk("len0_no_activity", 64'(act_cnt - base), 64'd0);

        // Abort after two operands, then a clean restart
        load_job(8'h60, 8'h90, 8, 32'h5A00_0000);
        exp_q.delete();
        wr(A_LEN, 8); wr(A_BIN, 8'h60); wr(A_BOUT, 8'h90);
        base = hs_cnt;
        wr(A_CTRL, 32'h1);
        seen = 0;
        for (int n = 0; n < 100 && seen == 0; n++) begin
            if (hs_cnt - base >= 2) seen = 1;
            else @(negedge clk);
        end
        chk("abort_2ops", 64'(seen), 64'd1);
        wr(A_CTRL, 32'h3);
        chk("abort_flush", 64'(k_flush), 64'd1);
        chk("abort_kvalid", 64'(k_in_valid), 64'd0);
        @(negedge clk);
        chk("abort_flush_end", 64'(k_flush), 64'd0);
        rd(A_STATUS, d); chk("abort_status", 64'(d), 64'h4);
        obs_q.delete();
        load_job(8'h60, 8'h90, 3, 32'h5A00_0000);
        wr(A_LEN, 3);
        wr(A_CTRL, 32'h1);
        run_job("restart", 3, 1'b0);
        rd(A_STATUS, d); chk("restart_status", 64'(d), 64'h2);

        // ABORT while idle does nothing
        wr(A_CTRL, 32'h2);
        @(negedge clk);
        rd(A_STATUS, d); chk("idle_abort", 64'(d), 64'h2);

        // IRQ, plus START/LENGTH writes during BUSY
        load_job(8'h50, 8'hB0, 2, 32'h1234_0000);
        wr(A_CTRL, 32'h4);
        wr(A_LEN, 2); wr(A_BIN, 8'h50); wr(A_BOUT, 8'hB0);
        wr(A_CTRL, 32'h5);
        wr(A_CTRL, 32'h5);
        wr(A_LEN, 100);
        run_job("irq", 2, 1'b1);
        rd(A_LEN, d); chk("busy_len_ignored", 64'(d), 64'd2);
        rd(A_STATUS, d); chk("irq_status", 64'(d), 64'h2);
        chk("irq_level", 64'(irq), 64'd1);
        wr(A_STATUS, 32'h2);
        chk("irq_cleared", 64'(irq), 64'd0);
        rd(A_STATUS, d); chk("done_w1c", 64'(d), 64'h0);
        wr(A_CTRL, 32'h0);

        // Kernel back-pressure: operand must hold while ready is low
        load_job(8'h70, 8'hA0, 3, 32'h7700_0000);
        wr(A_LEN, 3); wr(A_BIN, 8'h70); wr(A_BOUT, 8'hA0);
        ready_en = 1'b0;
        base = busy_cyc;
        wr(A_CTRL, 32'h1);
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            if (k_in_valid) seen = 1;
            else @(negedge clk);
        end
        chk("bp_valid", 64'(seen), 64'd1);
        d0 = k_in_data;
        chk("bp_data", 64'(d0), 64'h7700_0000);
        stable_err = 0;
        repeat (10) begin
            @(negedge clk);
            if (!k_in_valid || k_in_data !== d0) stable_err++;
        end
        chk("bp_stable", 64'(stable_err), 64'd0);
        ready_en = 1'b1;
        run_job("bp", 3, 1'b0);
        rd(A_CYC, d);
`ifdef KERNEL_SEQUENCER_CYCLE_COUNT_EN
        chk("cycles", 64'(d), 64'(busy_cyc - base));
`else
        chk("cycles_off", 64'(d), 64'd0);
`endif
        rd(8'h3F, d); chk("unmapped", 64'(d), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kernel_sequencer.md
# kernel_sequencer

Fabric-side job controller sitting behind the HPS bridge of the memory I/O system. The HPS programs it through the `data_control` register port; on START it streams LENGTH words from the input buffer RAM (filled by HPS via `data_in`) into a numerical kernel over a valid/ready stream. It writes kernel results into the output buffer RAM (read back by HPS via `data_out`), then raises DONE and an optional interrupt.

## Interface
Parameters:
- none (buffer depth fixed at 256 words × 32 bits, 8-bit addresses)

Ports:
- `clk_clk`  in  1  single clock for all logic
- `reset_reset_n`  in  1  reset; synchronous, active-low
- `ctrl_address`  in  8  register word address
- `ctrl_read`  in  1  register read strobe
- `ctrl_write`  in  1  register write strobe
- `ctrl_writedata`  in  32  register write data
- `ctrl_readdata`  out  32  register read data, fixed read latency 1
- `in_ram_address`  out  8  input buffer read address
- `in_ram_readdata`  in  32  input buffer data, 1-cycle synchronous RAM latency
- `out_ram_address`  out  8  output buffer write address
- `out_ram_write`  out  1  output buffer write strobe
- `out_ram_writedata`  out  32  output buffer write data
- `k_in_valid` / `k_in_ready`  out/in  1  operand stream handshake
- `k_in_data`  out  32  operand
- `k_out_valid` / `k_out_ready`  in/out  1  result stream handshake
- `k_out_data`  in  32  result
- `k_flush`  out  1  one-cycle pulse clearing kernel state on abort
- `irq`  out  1  DONE & IRQ_EN

## Operation
Registers (word addresses):
- 0x00 CTRL: bit0 START (write-1 pulse), bit1 ABORT (write-1 pulse), bit2 IRQ_EN (R/W)
- 0x01 STATUS (RO except DONE): bit0 BUSY, bit1 DONE (sticky, W1C), bit2 ABORTED (sticky, cleared by START)
- 0x02 LENGTH: 9 bits; writes >256 saturate to 256
- 0x03 BASE_IN, 0x04 BASE_OUT: 8 bits
- 0x05 RESULT_COUNT: results written this job, RO
- 0x06 CYCLES: see Configuration
- Unmapped addresses read 0; writes are ignored.
- Writes to LENGTH/BASE_IN/BASE_OUT while BUSY are ignored.

Feed FSM:
- IDLE: START → ISSUE; clears DONE, ABORTED, rd_cnt, wr_cnt.
- ISSUE: `in_ram_address` = BASE_IN + rd_cnt (mod 256) → CAPTURE.
- CAPTURE: register `in_ram_readdata` into `k_in_data` → PRESENT.
- PRESENT: `k_in_valid`=1, held stable until `k_in_ready`. On handshake: rd_cnt++, then → ISSUE if rd_cnt+1 < LENGTH, else → DRAIN.
- DRAIN: wait until wr_cnt == LENGTH → IDLE, set DONE.

Result side:
- `k_out_ready` = BUSY & (wr_cnt < LENGTH).
- On each `k_out_valid & k_out_ready`: `out_ram_write`=1, `out_ram_address` = BASE_OUT + wr_cnt (mod 256), `out_ram_writedata` = `k_out_data`; wr_cnt++. This happens combinationally in the same cycle.

Boundary cases:
- START while BUSY: ignored.
- START with LENGTH=0: no RAM or stream activity; DONE set next cycle.
- ABORT while BUSY: → IDLE next cycle, `k_flush` pulse, ABORTED=1, DONE not set, `k_in_valid` drops.
- ABORT while idle: no effect.
- START and ABORT in the same write: ABORT wins, no job starts.
- Buffer addresses wrap mod 256.
- `irq` = DONE & IRQ_EN; clearing either drops it the next cycle.

## Timing
- Reset values: all registers 0, FSM IDLE. All outputs 0 (`ctrl_readdata`, addresses, strobes, `k_*`, `k_flush`, `irq`).
- START written at cycle T: BUSY readable 1 from T+1; ISSUE at T+1; CAPTURE at T+2; `k_in_valid` at T+3.
- Input throughput: one operand per 3 cycles with `k_in_ready` held high.
- Last result write at cycle W: BUSY=0, DONE=1 at W+1; `irq` at W+1 if IRQ_EN.
- `ctrl_readdata` is valid the cycle after `ctrl_read` and holds until the next read.

## Configuration
- `KERNEL_SEQUENCER_CYCLE_COUNT_EN` defined: CYCLES (0x06) is a 32-bit counter that clears on START, increments every BUSY cycle, and saturates at 0xFFFFFFFF.
- Undefined: no counter logic; 0x06 reads 0.

## Structure
- `kernel_sequencer_pkg`: register address constants, CTRL/STATUS bit indices, FSM state enum, MAX_LENGTH=256.
- One sub-module `kernel_sequencer_csr`: register decode, readback mux, sticky bits, irq. The FSM and counters live in the top level.

## Test plan
- LENGTH=4, BASE_IN=0x10, BASE_OUT=0x20, echo kernel, RAM[0x10..0x13]=1..4 → RAM[0x20..0x23]=1..4, DONE=1, RESULT_COUNT=4, BUSY low one cycle after the 4th write.
- BASE_IN=0xFE, LENGTH=3 → reads from addresses 0xFE, 0xFF, 0x00; writes wrap identically.
- LENGTH=0, START → DONE=1 at T+1; no `in_ram`/`k_in_valid`/`out_ram_write` activity.
- ABORT after 2 operands accepted, LENGTH=8 → `k_flush` pulse, ABORTED=1, DONE=0, BUSY=0; next START runs cleanly.
- IRQ_EN=1, job completes → `irq`=1; write DONE=1 to STATUS → `irq`=0 next cycle. START during BUSY and a LENGTH write during BUSY → both ignored.
- `k_in_ready` held low 10 cycles mid-job → `k_in_data` stable throughout; with macro, CYCLES equals the BUSY cycle count.
